// File: rtl/conv_defs.sv
// Shared widths and saturation bounds for the conv_mult9 datapath.
package conv_defs;

    localparam int SIZE_1_DEF = 11;

    function automatic int prod_w(input int s);
        return 2 * s;
    endfunction

    function automatic int acc_w(input int s);
        return 2 * s + 4;
    endfunction

    function automatic int y_w(input int s);
        return 2 * s - 1;
    endfunction

    function automatic longint sat_max(input int s);
        return (64'sd1 <<< (y_w(s) - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int s);
        return -(64'sd1 <<< (y_w(s) - 1));
    endfunction

    localparam int PROD_W_DEF = 2 * SIZE_1_DEF;
    localparam int ACC_W_DEF  = 2 * SIZE_1_DEF + 4;
    localparam int Y_W_DEF    = 2 * SIZE_1_DEF - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } conv_state_t;

endpackage

// File: rtl/conv_mult_lane.sv
// One signed tap multiplier with a go-enabled capture register.
import conv_defs::*;

module conv_mult_lane #(
    parameter int SIZE_1 = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [SIZE_1-1:0]   a,
    input  logic signed [SIZE_1-1:0]   b,
    output logic signed [2*SIZE_1-1:0] prod
);

    logic signed [2*SIZE_1-1:0] mul;

    assign mul = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= mul;
        end
    end

endmodule

// File: rtl/conv_mult9.sv
// 3x3 window x kernel multiply-accumulate with one capture stage.
// Define CONV_MULT_SAT_EN to clip Y1 and report ovf; otherwise Y1 wraps.
import conv_defs::*;

module conv_mult9 #(
    parameter int SIZE_1 = 11,
    parameter int CNT_W  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic signed [SIZE_1-1:0]   p1,
    input  logic signed [SIZE_1-1:0]   p2,
    input  logic signed [SIZE_1-1:0]   p3,
    input  logic signed [SIZE_1-1:0]   p4,
    input  logic signed [SIZE_1-1:0]   p5,
    input  logic signed [SIZE_1-1:0]   p6,
    input  logic signed [SIZE_1-1:0]   p7,
    input  logic signed [SIZE_1-1:0]   p8,
    input  logic signed [SIZE_1-1:0]   p9,
    input  logic signed [SIZE_1-1:0]   w11,
    input  logic signed [SIZE_1-1:0]   w12,
    input  logic signed [SIZE_1-1:0]   w13,
    input  logic signed [SIZE_1-1:0]   w14,
    input  logic signed [SIZE_1-1:0]   w15,
    input  logic signed [SIZE_1-1:0]   w16,
    input  logic signed [SIZE_1-1:0]   w17,
    input  logic signed [SIZE_1-1:0]   w18,
    input  logic signed [SIZE_1-1:0]   w19,
    output logic signed [2*SIZE_1-2:0] Y1,
    output logic                       y_valid,
    output logic                       ovf,
    output logic [CNT_W-1:0]           res_cnt
);

    localparam int PROD_W = prod_w(SIZE_1);
    localparam int ACC_W  = acc_w(SIZE_1);
    localparam int Y_W    = y_w(SIZE_1);

    logic signed [SIZE_1-1:0] pa [9];
    logic signed [SIZE_1-1:0] wa [9];
    logic signed [PROD_W-1:0] prod [9];
    logic signed [ACC_W-1:0]  ext [9];

    assign pa = '{p1, p2, p3, p4, p5, p6, p7, p8, p9};
    assign wa = '{w11, w12, w13, w14, w15, w16, w17, w18, w19};

    for (genvar k = 0; k < 9; k++) begin : g_lane
        conv_mult_lane #(.SIZE_1(SIZE_1)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (go),
            .a    (pa[k]),
            .b    (wa[k]),
            .prod (prod[k])
        );
        assign ext[k] = ACC_W'(prod[k]);
    end

    logic signed [ACC_W-1:0] s1a, s1b, s1c, s1d;
    logic signed [ACC_W-1:0] s2a, s2b, s3, sum;

    assign s1a = ext[0] + ext[1];
    assign s1b = ext[2] + ext[3];
    assign s1c = ext[4] + ext[5];
    assign s1d = ext[6] + ext[7];
    assign s2a = s1a + s1b;
    assign s2b = s1c + s1d;
    assign s3  = s2a + s2b;
    assign sum = s3 + ext[8];

`ifdef CONV_MULT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(SIZE_1));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(SIZE_1));

    always_comb begin
        Y1  = sum[Y_W-1:0];
        ovf = 1'b0;
        if (sum > SAT_MAX) begin
            Y1  = SAT_MAX[Y_W-1:0];
            ovf = 1'b1;
        end else if (sum < SAT_MIN) begin
            Y1  = SAT_MIN[Y_W-1:0];
            ovf = 1'b1;
        end
    end
`else
    logic unused_hi;

    // upper accumulator bits are discarded in the wrapping build
    assign unused_hi = ^sum[ACC_W-1:Y_W];
    assign Y1        = sum[Y_W-1:0];
    assign ovf       = 1'b0;
`endif

    conv_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            y_valid <= 1'b0;
            res_cnt <= '0;
        end else if (go) begin
            state   <= ST_HOLD;
            y_valid <= 1'b1;
            res_cnt <= res_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_conv_mult9.sv
// Directed self-checking bench for conv_mult9.
module tb_conv_mult9;

    localparam int S  = 11;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0;
    logic signed [S-1:0] p [9];
    logic signed [S-1:0] w [9];
    logic signed [2*S-2:0] Y1;
    logic y_valid;
    logic ovf;
    logic [CW-1:0] res_cnt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv_mult9 #(.SIZE_1(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .p1(p[0]), .p2(p[1]), .p3(p[2]),
        .p4(p[3]), .p5(p[4]), .p6(p[5]),
        .p7(p[6]), .p8(p[7]), .p9(p[8]),
        .w11(w[0]), .w12(w[1]), .w13(w[2]),
        .w14(w[3]), .w15(w[4]), .w16(w[5]),
        .w17(w[6]), .w18(w[7]), .w19(w[8]),
        .Y1(Y1), .y_valid(y_valid), .ovf(ovf),
        .res_cnt(res_cnt)
    );

    task automatic set_zero();
        for (int i = 0; i < 9; i++) begin
            p[i] = '0;
            w[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        go = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one go cycle; sample 1 ns after the capture edge
    task automatic capture();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic test_reset();
        set_zero();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (Y1 !== 0 || y_valid !== 1'b0 || res_cnt !== 0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: Y1=%0d v=%b cnt=%0d want 0/0/0",
                         c, Y1, y_valid, res_cnt);
            end
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 9; i++) begin
            p[i] = S'(i + 1);
            w[i] = 11'sd2;
        end
        capture();
        n_checks++;
        if (Y1 !== 90 || y_valid !== 1'b1 || res_cnt !== 1) begin
            n_fail++;
            $display("FAIL single: Y1=%0d v=%b cnt=%0d want 90/1/1",
                     Y1, y_valid, res_cnt);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) begin
                p[i] = S'($urandom);
                w[i] = S'($urandom);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (Y1 !== 90 || y_valid !== 1'b1 || res_cnt !== 1) begin
                n_fail++;
                $display("FAIL hold c%0d: Y1=%0d v=%b cnt=%0d want 90/1/1",
                         c, Y1, y_valid, res_cnt);
            end
        end
    endtask

    task automatic test_mixed();
        int pv [9] = '{-3, 5, 0, 7, -1, 2, 4, -6, 1};
        int wv [9] = '{2, -1, 9, 1, 3, -4, 0, 1, -5};
        for (int i = 0; i < 9; i++) begin
            p[i] = S'(pv[i]);
            w[i] = S'(wv[i]);
        end
        capture();
        n_checks++;
        if (Y1 !== -26 || ovf !== 1'b0 || res_cnt !== 2) begin
            n_fail++;
            $display("FAIL mixed: Y1=%0d ovf=%b cnt=%0d want -26/0/2",
                     Y1, ovf, res_cnt);
        end
    endtask

    task automatic test_overflow();
        logic signed [2*S-2:0] y_exp;
        logic ovf_exp;
`ifdef CONV_MULT_SAT_EN
        y_exp = 21'sd1048575;
        ovf_exp = 1'b1;
`else
        y_exp = -21'sd1048576;
        ovf_exp = 1'b0;
`endif
        for (int i = 0; i < 9; i++) begin
            p[i] = -11'sd1024;
            w[i] = -11'sd1024;
        end
        capture();
        n_checks++;
        if (Y1 !== y_exp || ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL overflow: Y1=%0d ovf=%b want %0d/%b",
                     Y1, ovf, y_exp, ovf_exp);
        end
        @(negedge clk);
        set_zero();
        @(posedge clk);
        #1;
        n_checks++;
        if (Y1 !== y_exp || ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL overflow_hold: Y1=%0d ovf=%b want %0d/%b",
                     Y1, ovf, y_exp, ovf_exp);
        end
    endtask

    task automatic test_back_to_back();
        int sums [3] = '{10, 20, 30};
        do_reset();
        set_zero();
        w[0] = 11'sd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            go = 1'b1;
            p[0] = S'(sums[k]);
            @(posedge clk);
            #1;
            n_checks++;
            if (Y1 !== sums[k] || res_cnt !== CW'(k + 1)) begin
                n_fail++;
                $display("FAIL b2b k%0d: Y1=%0d cnt=%0d want %0d/%0d",
                         k, Y1, res_cnt, sums[k], k + 1);
            end
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (Y1 !== 30 || res_cnt !== 3 || y_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: Y1=%0d cnt=%0d v=%b want 30/3/1",
                     Y1, res_cnt, y_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (Y1 !== 0 || y_valid !== 1'b0 || ovf !== 1'b0 || res_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid: Y1=%0d v=%b ovf=%b cnt=%0d want 0",
                     Y1, y_valid, ovf, res_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_zero();
        p[8] = 11'sd7;
        w[8] = -11'sd3;
        capture();
        n_checks++;
        if (Y1 !== -21 || y_valid !== 1'b1 || res_cnt !== 1) begin
            n_fail++;
            $display("FAIL after_reset: Y1=%0d v=%b cnt=%0d want -21/1/1",
                     Y1, y_valid, res_cnt);
        end
    endtask

    initial begin
        set_zero();
        test_reset();
        test_single();
        test_mixed();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
